// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory port: responder FSM encoding,
// word geometry and the address checks used by both ends of the port.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    localparam int          WORD_BYTES      = 4;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'(WORD_BYTES - 1);

    // A request is bad when it is not word aligned or its word index falls
    // past the end of the RAM.
    function automatic logic addr_error(input logic [31:0] a, input int depth);
        logic misaligned;
        logic out_of_range;
        misaligned   = (a & ADDR_ALIGN_MASK) != 32'd0;
        out_of_range = (a >> 2) >= $unsigned(depth);
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-wide data RAM: synchronous write, asynchronous read. Contents are
// deliberately not reset.
module data_mem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Commit one word per cycle when the responder asks for it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory port. Accepts one request at a time,
// waits WAIT_STATES cycles, then presents a registered one-cycle ack with
// read data or a write commit and an error flag.
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    mem_state_e    state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          lat_we_reg, lat_we_next;
    logic          lat_err_reg, lat_err_next;
    logic [AW-1:0] lat_idx_reg, lat_idx_next;
    logic [31:0]   lat_wdata_reg, lat_wdata_next;
    logic          busy_reg, busy_next;
    logic          ack_reg, ack_next;
    logic          err_reg, err_next;
    logic [31:0]   rdata_reg, rdata_next;

    logic          accept;
    logic          eff_we;
    logic          eff_err;
    logic [AW-1:0] eff_idx;
    logic          ram_we;
    logic [31:0]   ram_rdata;

    // With zero wait states the response is built in the accept cycle itself,
    // so the fields used for it come straight from the request pins then.
    assign accept  = (state_reg == ST_IDLE) && req;
    assign eff_we  = accept ? we : lat_we_reg;
    assign eff_err = accept ? addr_error(addr, DEPTH_WORDS) : lat_err_reg;
    assign eff_idx = accept ? addr[AW+1:2] : lat_idx_reg;

    // The write lands on the clock edge that closes the RESP cycle; a reset
    // before that edge forces IDLE and the write never happens.
    assign ram_we = (state_reg == ST_RESP) && lat_we_reg && !lat_err_reg;

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .waddr (lat_idx_reg),
        .wdata (lat_wdata_reg),
        .raddr (eff_idx),
        .rdata (ram_rdata)
    );

    // Next-state, request latch, wait counter and registered response values.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        lat_we_next    = lat_we_reg;
        lat_err_next   = lat_err_reg;
        lat_idx_next   = lat_idx_reg;
        lat_wdata_next = lat_wdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    lat_we_next    = we;
                    lat_err_next   = addr_error(addr, DEPTH_WORDS);
                    lat_idx_next   = addr[AW+1:2];
                    lat_wdata_next = wdata;
                    if (WAIT_STATES == 0) begin
                        state_next = ST_RESP;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = ST_RESP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase

        busy_next  = (state_next != ST_IDLE);
        ack_next   = (state_next == ST_RESP);
        err_next   = ack_next && eff_err;
        rdata_next = (ack_next && !eff_we && !eff_err) ? ram_rdata : 32'd0;
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            lat_we_reg    <= 1'b0;
            lat_err_reg   <= 1'b0;
            lat_idx_reg   <= '0;
            lat_wdata_reg <= 32'd0;
            busy_reg      <= 1'b0;
            ack_reg       <= 1'b0;
            err_reg       <= 1'b0;
            rdata_reg     <= 32'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            lat_we_reg    <= lat_we_next;
            lat_err_reg   <= lat_err_next;
            lat_idx_reg   <= lat_idx_next;
            lat_wdata_reg <= lat_wdata_next;
            busy_reg      <= busy_next;
            ack_reg       <= ack_next;
            err_reg       <= err_next;
            rdata_reg     <= rdata_next;
        end
    end

    assign busy  = busy_reg;
    assign ack   = ack_reg;
    assign err   = err_reg;
    assign rdata = rdata_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (zero and two wait states). Stimulus pushes
// the expected response and its ack cycle; monitors pop and compare on ack.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        RST;
    logic        req0, we0, busy0, ack0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req2, we2, busy2, ack2, err2;
    logic [31:0] addr2, wdata2, rdata2;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .RST(RST), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .busy(busy0), .ack(ack0), .rdata(rdata0), .err(err0)
    );

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .RST(RST), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .busy(busy2), .ack(ack2), .rdata(rdata2), .err(err2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor for the zero-wait-state responder.
    always @(negedge clk) begin
        exp_t e;
        if (RST === 1'b1 && ack0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack_dut0: got ack at cyc %0d expected none", cyc);
            end else begin
                e = q0.pop_front();
                chk({e.name, "_rdata"}, rdata0, e.rdata);
                chk({e.name, "_err"}, {31'd0, err0}, {31'd0, e.err});
                chk({e.name, "_ack_cyc"}, cyc, e.cyc);
                $display("dut0 %s: ack cyc=%0d rdata=%h err=%0d", e.name, cyc, rdata0, err0);
            end
        end
    end

    // Monitor for the two-wait-state responder.
    always @(negedge clk) begin
        exp_t e;
        if (RST === 1'b1 && ack2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack_dut2: got ack at cyc %0d expected none", cyc);
            end else begin
                e = q2.pop_front();
                chk({e.name, "_rdata"}, rdata2, e.rdata);
                chk({e.name, "_err"}, {31'd0, err2}, {31'd0, e.err});
                chk({e.name, "_ack_cyc"}, cyc, e.cyc);
                $display("dut2 %s: ack cyc=%0d rdata=%h err=%0d", e.name, cyc, rdata2, err2);
            end
        end
    end

    task automatic drive(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = wd;
        end else begin
            req2 = r; we2 = w; addr2 = a; wdata2 = wd;
        end
    endtask

    task automatic push_exp(input int d, input string name, input logic [31:0] rd,
                            input logic e, input int ack_cyc);
        exp_t x;
        x.rdata = rd;
        x.err   = e;
        x.cyc   = ack_cyc;
        x.name  = name;
        if (d == 0) q0.push_back(x);
        else        q2.push_back(x);
    endtask

    // Returns at the negedge where ack is seen, or after a bounded wait.
    task automatic wait_ack(input int d, input string name);
        int n;
        logic a;
        n = 0;
        forever begin
            @(negedge clk);
            a = (d == 0) ? ack0 : ack2;
            if (a === 1'b1) break;
            n++;
            if (n > 40) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout: got no ack after %0d cycles expected ack", name, n);
                break;
            end
        end
    endtask

    // One full transaction; perturb scrambles the request pins while busy.
    task automatic txn(input int d, input string name, input logic w,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input bit perturb);
        @(negedge clk);
        push_exp(d, name, exp_rd, exp_err, cyc + 1 + ((d == 0) ? 0 : 2));
        drive(d, 1'b1, w, a, wd);
        if (perturb) begin
            @(negedge clk);
            drive(d, 1'b1, ~w, 32'h0000_0100, 32'h0BAD_0BAD);
        end
        wait_ack(d, name);
        drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int base;
        RST = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(2, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);

        // Reset held with a pending request: nothing may respond.
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy2}, 32'd0);
        chk("rst_ack", {31'd0, ack2}, 32'd0);
        chk("rst_err", {31'd0, err2}, 32'd0);
        chk("rst_rdata", rdata2, 32'd0);
        chk("rst_busy_dut0", {31'd0, busy0}, 32'd0);

        // Release: the held write is accepted on the very next edge.
        push_exp(2, "wr_10_after_rst", 32'd0, 1'b0, cyc + 3);
        RST = 1'b1;
        wait_ack(2, "wr_10_after_rst");
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0);

        txn(2, "rd_10", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        txn(2, "wr_13_misaligned", 1'b1, 32'h13, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        txn(2, "rd_10_after_mis", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        txn(2, "rd_10_perturbed", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        txn(2, "rd_100_oor", 1'b0, 32'h100, 32'd0, 32'd0, 1'b1, 1'b0);
        txn(2, "wr_fc", 1'b1, 32'hFC, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
        txn(2, "rd_fc", 1'b0, 32'hFC, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b0);

        // Back-to-back reads with req held high on the zero-wait responder.
        for (int i = 0; i < 4; i++) begin
            txn(0, "wr_b2b_fill", 1'b1, 32'(i * 4), 32'h1111_0000 + 32'(i), 32'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        base = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            push_exp(0, "rd_b2b", 32'h1111_0000 + 32'(i), 1'b0, base + 2 * i);
        end
        drive(0, 1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_ack(0, "rd_b2b");
            if (i < 3) drive(0, 1'b1, 1'b0, 32'((i + 1) * 4), 32'hFFFF_FFFF);
            else       drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        end

        // Reset in the middle of a write's wait states aborts it.
        txn(2, "wr_20_first", 1'b1, 32'h20, 32'hA5A5_0001, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 32'h20, 32'h5A5A_0002);
        @(negedge clk);
        #2 RST = 1'b0;
        #1;
        chk("midwait_rst_busy", {31'd0, busy2}, 32'd0);
        chk("midwait_rst_ack", {31'd0, ack2}, 32'd0);
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        RST = 1'b1;
        repeat (6) @(negedge clk);
        txn(2, "rd_20_after_abort", 1'b0, 32'h20, 32'd0, 32'hA5A5_0001, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(q0.size() + q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
